// File: rtl/register_file_mp.sv
// Multi-ported register file with a per-register busy scoreboard, same-cycle
// write-to-read bypass and an optional hardwired zero register.

module register_file_mp_rd #(
  parameter int Nloc   = 32,
  parameter int Dbits  = 32,
  parameter int A      = 5,
  parameter bit BYPASS = 1'b1
) (
  input  logic                       en,
  input  logic [A-1:0]               ra,
  input  logic [Nloc-1:0][Dbits-1:0] rf,
  input  logic [Nloc-1:0]            busy,
  input  logic [Nloc-1:0]            whit,
  input  logic [Nloc-1:0][Dbits-1:0] wval,
  input  logic [Nloc-1:0]            rhit,
  output logic [Dbits-1:0]           rd,
  output logic                       rb
);
  // Addresses past Nloc read as an empty, idle register.
  always_comb begin
    rd = '0;
    rb = 1'b0;
    if (en && int'(ra) < Nloc) begin
      if (BYPASS && whit[ra]) begin
        rd = wval[ra];
        rb = rhit[ra];
      end else begin
        rd = rf[ra];
        rb = busy[ra];
      end
    end
  end
endmodule

module register_file_mp #(
  parameter  int Nloc     = 32,
  parameter  int Dbits    = 32,
  parameter  int NR       = 2,
  parameter  int NW       = 1,
  parameter  bit ZERO_REG = 1'b1,
  parameter  bit BYPASS   = 1'b1,
  localparam int A        = (Nloc > 1) ? $clog2(Nloc) : 1,
  localparam int CW       = $clog2(Nloc + 1)
) (
  input  logic                clock,
  input  logic                reset_n,
  input  logic [NW-1:0]       wr,
  input  logic [NW*A-1:0]     WriteAddr,
  input  logic [NW*Dbits-1:0] WriteData,
  input  logic [NR*A-1:0]     ReadAddr,
  output logic [NR*Dbits-1:0] ReadData,
  output logic [NR-1:0]       ReadBusy,
  input  logic                reserve,
  input  logic [A-1:0]        ReserveAddr,
  output logic [CW-1:0]       BusyCount
);
  if (NR < 1 || NW < 1) begin : g_bad_ports
    $error("register_file_mp: NR and NW must both be >= 1");
  end

  logic [Nloc-1:0][Dbits-1:0] rf_q, rf_d;
  logic [Nloc-1:0]            busy_q, busy_d;
  logic [CW-1:0]              busy_count_q, busy_count_d;
  logic [Nloc-1:0]            whit, rhit;
  logic [Nloc-1:0][Dbits-1:0] wval;

  // Per-register write/reserve decode; ascending port scan lets the highest
  // enabled port win a conflict. Out-of-range addresses match no register.
  always_comb begin
    whit = '0;
    wval = '0;
    rhit = '0;
    for (int a = 0; a < Nloc; a++) begin
      if (a != 0 || !ZERO_REG) begin
        for (int k = 0; k < NW; k++) begin
          if (wr[k] && int'(WriteAddr[k*A +: A]) == a) begin
            whit[a] = 1'b1;
            wval[a] = WriteData[k*Dbits +: Dbits];
          end
        end
        rhit[a] = reserve && int'(ReserveAddr) == a;
      end
    end
  end

  // A reserve landing with a write leaves the register busy for the new producer.
  always_comb begin
    rf_d         = rf_q;
    busy_d       = busy_q;
    busy_count_d = '0;
    for (int a = 0; a < Nloc; a++) begin
      if (whit[a]) begin
        rf_d[a]   = wval[a];
        busy_d[a] = 1'b0;
      end
      if (rhit[a]) busy_d[a] = 1'b1;
      busy_count_d = busy_count_d + CW'(busy_d[a]);
    end
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      rf_q         <= '0;
      busy_q       <= '0;
      busy_count_q <= '0;
    end else begin
      rf_q         <= rf_d;
      busy_q       <= busy_d;
      busy_count_q <= busy_count_d;
    end
  end

  assign BusyCount = busy_count_q;

  for (genvar j = 0; j < NR; j++) begin : g_rd
    register_file_mp_rd #(
      .Nloc(Nloc), .Dbits(Dbits), .A(A), .BYPASS(BYPASS)
    ) u_rd (
      .en  (reset_n),
      .ra  (ReadAddr[j*A +: A]),
      .rf  (rf_q),
      .busy(busy_q),
      .whit(whit),
      .wval(wval),
      .rhit(rhit),
      .rd  (ReadData[j*Dbits +: Dbits]),
      .rb  (ReadBusy[j])
    );
  end
endmodule

// File: tb/tb_register_file_mp.sv
// Directed and randomized checks of register_file_mp: one 4R/2W bypassing
// instance and one 2R/1W non-bypassing, non-power-of-2 instance.

module tb_register_file_mp;
  logic clock = 1'b0;
  logic reset_n = 1'b0;
  always #5 clock = ~clock;

  // Instance A: Nloc=32, NR=4, NW=2, ZERO_REG=1, BYPASS=1
  logic [1:0]   wr_a;
  logic [9:0]   wad_a;
  logic [63:0]  wdt_a;
  logic [19:0]  rad_a;
  logic [127:0] rdt_a;
  logic [3:0]   rbz_a;
  logic         rsv_a;
  logic [4:0]   rsa_a;
  logic [5:0]   bc_a;

  // Instance B: Nloc=24, NR=2, NW=1, ZERO_REG=0, BYPASS=0
  logic [0:0]   wr_b;
  logic [4:0]   wad_b;
  logic [31:0]  wdt_b;
  logic [9:0]   rad_b;
  logic [63:0]  rdt_b;
  logic [1:0]   rbz_b;
  logic         rsv_b;
  logic [4:0]   rsa_b;
  logic [4:0]   bc_b;

  register_file_mp #(.Nloc(32), .Dbits(32), .NR(4), .NW(2), .ZERO_REG(1'b1), .BYPASS(1'b1)) dut_a (
    .clock(clock), .reset_n(reset_n), .wr(wr_a), .WriteAddr(wad_a), .WriteData(wdt_a),
    .ReadAddr(rad_a), .ReadData(rdt_a), .ReadBusy(rbz_a), .reserve(rsv_a),
    .ReserveAddr(rsa_a), .BusyCount(bc_a));

  register_file_mp #(.Nloc(24), .Dbits(32), .NR(2), .NW(1), .ZERO_REG(1'b0), .BYPASS(1'b0)) dut_b (
    .clock(clock), .reset_n(reset_n), .wr(wr_b), .WriteAddr(wad_b), .WriteData(wdt_b),
    .ReadAddr(rad_b), .ReadData(rdt_b), .ReadBusy(rbz_b), .reserve(rsv_b),
    .ReserveAddr(rsa_b), .BusyCount(bc_b));

  int n_cmp = 0;
  int n_err = 0;

  logic [31:0] m_rf [32];
  logic        m_bz [32];

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic idle();
    wr_a = '0; rsv_a = 1'b0; wr_b = '0; rsv_b = 1'b0;
  endtask

  task automatic wa(input int k, input logic [4:0] ad, input logic [31:0] d);
    wr_a[k] = 1'b1; wad_a[k*5 +: 5] = ad; wdt_a[k*32 +: 32] = d;
  endtask

  task automatic ra(input int j, input logic [4:0] ad);
    rad_a[j*5 +: 5] = ad;
  endtask

  function automatic logic [31:0] rd_a(input int j);
    return rdt_a[j*32 +: 32];
  endfunction

  task automatic tick();
    @(posedge clock); #1;
  endtask

  function automatic logic [4:0] rnd_addr();
    return ($urandom_range(0, 3) == 0) ? 5'($urandom_range(0, 31)) : 5'($urandom_range(0, 7));
  endfunction

  initial begin
    idle();
    wad_a = '0; wdt_a = '0; rad_a = '0; rsa_a = '0;
    wad_b = '0; wdt_b = '0; rad_b = '0; rsa_b = '0;
    repeat (2) @(posedge clock);
    #1;
    chk("rst_bc_a", 64'(bc_a), 64'd0);
    chk("rst_busy_a", 64'(rbz_a), 64'd0);
    chk("rst_data_a", rdt_a[63:0], 64'd0);
    chk("rst_bc_b", 64'(bc_b), 64'd0);
    reset_n = 1'b1;

    // Fill and reserve r5, then reset asynchronously
    wa(0, 5'd5, 32'hDEADBEEF); tick();
    idle(); rsv_a = 1'b1; rsa_a = 5'd5; tick();
    idle(); ra(0, 5'd5); #3;
    chk("r5_data", 64'(rd_a(0)), 64'hDEADBEEF);
    chk("r5_busy", 64'(rbz_a[0]), 64'd1);
    chk("r5_bc", 64'(bc_a), 64'd1);
    reset_n = 1'b0; #1;
    chk("arst_data", 64'(rd_a(0)), 64'd0);
    chk("arst_busy", 64'(rbz_a[0]), 64'd0);
    chk("arst_bc", 64'(bc_a), 64'd0);
    wa(0, 5'd5, 32'hCAFE0000); rsv_a = 1'b1; rsa_a = 5'd6; #1;
    chk("inrst_bypass", 64'(rd_a(0)), 64'd0);
    tick();
    chk("inrst_bc", 64'(bc_a), 64'd0);
    idle(); reset_n = 1'b1; #3;
    chk("postrst_data", 64'(rd_a(0)), 64'd0);
    chk("postrst_busy", 64'(rbz_a[0]), 64'd0);

    // r0 is hardwired
    wa(0, 5'd0, 32'h1234); rsv_a = 1'b1; rsa_a = 5'd0; ra(1, 5'd0); #3;
    chk("r0_byp_data", 64'(rd_a(1)), 64'd0);
    chk("r0_byp_busy", 64'(rbz_a[1]), 64'd0);
    tick(); idle(); #3;
    chk("r0_data", 64'(rd_a(1)), 64'd0);
    chk("r0_bc", 64'(bc_a), 64'd0);

    // Write conflict: port 1 wins
    wa(0, 5'd7, 32'h11); wa(1, 5'd7, 32'h22); ra(2, 5'd7); #3;
    chk("conf_byp", 64'(rd_a(2)), 64'h22);
    tick(); idle(); #3;
    chk("conf_store", 64'(rd_a(2)), 64'h22);

    // Bypass on A, none on B
    wa(0, 5'd3, 32'hA5A5A5A5); ra(3, 5'd3);
    wr_b = 1'b1; wad_b = 5'd3; wdt_b = 32'hA5A5A5A5; rad_b[4:0] = 5'd3; #3;
    chk("byp_a_data", 64'(rd_a(3)), 64'hA5A5A5A5);
    chk("byp_a_busy", 64'(rbz_a[3]), 64'd0);
    chk("nobyp_b_old", 64'(rdt_b[31:0]), 64'd0);
    tick(); idle(); #3;
    chk("nobyp_b_new", 64'(rdt_b[31:0]), 64'hA5A5A5A5);
    chk("byp_a_store", 64'(rd_a(3)), 64'hA5A5A5A5);

    // Scoreboard counting
    rsv_a = 1'b1; rsa_a = 5'd9; tick();
    rsa_a = 5'd10; tick();
    idle(); ra(0, 5'd9); ra(1, 5'd10); #3;
    chk("bc_two", 64'(bc_a), 64'd2);
    chk("busy_9_10", 64'(rbz_a[1:0]), 64'b11);
    wa(0, 5'd9, 32'h99); tick(); idle(); #3;
    chk("bc_one", 64'(bc_a), 64'd1);
    chk("busy_after_wb", 64'(rbz_a[1:0]), 64'b10);
    chk("r9_data", 64'(rd_a(0)), 64'h99);
    wa(1, 5'd10, 32'h77); rsv_a = 1'b1; rsa_a = 5'd10; #3;
    chk("wr_rsv_byp_data", 64'(rd_a(1)), 64'h77);
    chk("wr_rsv_byp_busy", 64'(rbz_a[1]), 64'd1);
    tick(); idle(); #3;
    chk("wr_rsv_bc", 64'(bc_a), 64'd1);
    chk("wr_rsv_busy", 64'(rbz_a[1]), 64'd1);
    chk("wr_rsv_data", 64'(rd_a(1)), 64'h77);
    rsv_a = 1'b1; rsa_a = 5'd10; wa(0, 5'd3, 32'h5); tick(); idle(); #3;
    chk("rersv_bc", 64'(bc_a), 64'd1);
    wa(0, 5'd10, 32'h88); #3;
    chk("wb_byp_busy", 64'(rbz_a[1]), 64'd0);
    chk("wb_byp_data", 64'(rd_a(1)), 64'h88);
    tick(); idle(); #3;
    chk("wb_bc", 64'(bc_a), 64'd0);

    // B: out-of-range addresses, r0 is an ordinary register, no bypass of busy
    wr_b = 1'b1; wad_b = 5'd25; wdt_b = 32'hFFFF; rsv_b = 1'b1; rsa_b = 5'd30; rad_b[9:5] = 5'd25; #3;
    chk("oor_byp_data", 64'(rdt_b[63:32]), 64'd0);
    chk("oor_byp_busy", 64'(rbz_b[1]), 64'd0);
    tick(); idle(); #3;
    chk("oor_bc", 64'(bc_b), 64'd0);
    chk("oor_data", 64'(rdt_b[63:32]), 64'd0);
    wr_b = 1'b1; wad_b = 5'd0; wdt_b = 32'h42; rsv_b = 1'b1; rsa_b = 5'd0; rad_b[4:0] = 5'd0;
    tick(); idle(); #3;
    chk("b_r0_data", 64'(rdt_b[31:0]), 64'h42);
    chk("b_r0_busy", 64'(rbz_b[0]), 64'd1);
    chk("b_r0_bc", 64'(bc_b), 64'd1);
    wr_b = 1'b1; wad_b = 5'd0; wdt_b = 32'h43; #3;
    chk("b_nobyp_data", 64'(rdt_b[31:0]), 64'h42);
    chk("b_nobyp_busy", 64'(rbz_b[0]), 64'd1);
    tick(); idle(); #3;
    chk("b_wb_data", 64'(rdt_b[31:0]), 64'h43);
    chk("b_wb_busy", 64'(rbz_b[0]), 64'd0);
    chk("b_wb_bc", 64'(bc_b), 64'd0);

    // Random mix on A against a reference model, starting from a clean reset
    reset_n = 1'b0; #2; reset_n = 1'b1;
    for (int i = 0; i < 32; i++) begin m_rf[i] = '0; m_bz[i] = 1'b0; end
    tick();
    for (int i = 0; i < 2000; i++) begin
      int cnt;
      for (int k = 0; k < 2; k++) begin
        wr_a[k] = 1'($urandom_range(0, 1));
        wad_a[k*5 +: 5] = rnd_addr();
        wdt_a[k*32 +: 32] = $urandom();
      end
      rsv_a = ($urandom_range(0, 9) < 3);
      rsa_a = rnd_addr();
      for (int j = 0; j < 4; j++) ra(j, rnd_addr());
      #3;
      for (int j = 0; j < 4; j++) begin
        logic [4:0]  a;
        logic [31:0] ed;
        logic        eb;
        a = rad_a[j*5 +: 5];
        ed = m_rf[a];
        eb = m_bz[a];
        for (int k = 0; k < 2; k++)
          if (wr_a[k] && wad_a[k*5 +: 5] == a) begin
            ed = wdt_a[k*32 +: 32];
            eb = rsv_a && (rsa_a == a);
          end
        if (a == 5'd0) begin ed = '0; eb = 1'b0; end
        chk("rnd_data", 64'(rd_a(j)), 64'(ed));
        chk("rnd_busy", 64'(rbz_a[j]), 64'(eb));
      end
      if (i == 1000) begin
        reset_n = 1'b0; #1;
        chk("rnd_rst_bc", 64'(bc_a), 64'd0);
        idle();
        for (int r = 0; r < 32; r++) begin m_rf[r] = '0; m_bz[r] = 1'b0; end
        reset_n = 1'b1;
        tick();
      end else begin
        for (int k = 0; k < 2; k++)
          if (wr_a[k] && wad_a[k*5 +: 5] != 5'd0) begin
            m_rf[wad_a[k*5 +: 5]] = wdt_a[k*32 +: 32];
            m_bz[wad_a[k*5 +: 5]] = 1'b0;
          end
        if (rsv_a && rsa_a != 5'd0) m_bz[rsa_a] = 1'b1;
        tick();
      end
      cnt = 0;
      for (int r = 0; r < 32; r++) cnt += int'(m_bz[r]);
      chk("rnd_bc", 64'(bc_a), 64'(cnt));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
